// File: rtl/core_port_arbiter_if.sv
// Simple request/response core port: one request channel with valid/ready,
// one completion pulse carrying read data and a response code.
interface core_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic                  resp_valid;
  logic                  resp_is_write;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [1:0]            resp_resp;

  // Side that issues requests and receives completions.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready,
    input  resp_valid, resp_is_write, resp_rdata, resp_resp
  );

  // Side that accepts requests and returns completions.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready,
    output resp_valid, resp_is_write, resp_rdata, resp_resp
  );
endinterface

// File: rtl/core_port_arbiter.sv
// Round-robin arbiter sharing one core port between two masters, with a
// single transaction in flight, completion steering and debug counters.
module core_port_arbiter #(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  core_port_arbiter_if.slave   m0,
  core_port_arbiter_if.slave   m1,
  core_port_arbiter_if.master  core,
  output logic [CNT_W-1:0]     grant_cnt0,
  output logic [CNT_W-1:0]     grant_cnt1,
  output logic [1:0]           dbg_state,
  output logic                 dbg_owner,
  output logic                 dbg_spurious_resp
);

  localparam int unsigned      STRB_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             spur_q, spur_d;

  logic                  own_valid;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic [STRB_W-1:0]     own_wstrb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Live request of the current owner.
  assign own_valid = owner_q ? m1.req_valid : m0.req_valid;
  assign own_we    = owner_q ? m1.req_we    : m0.req_we;
  assign own_addr  = owner_q ? m1.req_addr  : m0.req_addr;
  assign own_wdata = owner_q ? m1.req_wdata : m0.req_wdata;
  assign own_wstrb = owner_q ? m1.req_wstrb : m0.req_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      spur_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      spur_q       <= spur_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    cnt0_d          = cnt0_q;
    cnt1_d          = cnt1_q;
    spur_d          = spur_q;
    core.req_valid  = 1'b0;
    core.req_we     = 1'b0;
    core.req_addr   = '0;
    core.req_wdata  = '0;
    core.req_wstrb  = '0;
    m0.req_ready    = 1'b0;
    m1.req_ready    = 1'b0;
    m0.resp_valid   = 1'b0;
    m1.resp_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0.req_valid && m1.req_valid) begin
          owner_d = ~last_owner_q;
          state_d = ST_GRANT;
        end else if (m0.req_valid) begin
          owner_d = 1'b0;
          state_d = ST_GRANT;
        end else if (m1.req_valid) begin
          owner_d = 1'b1;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        core.req_valid = own_valid;
        core.req_we    = own_we;
        core.req_addr  = own_addr;
        core.req_wdata = own_wdata;
        core.req_wstrb = own_wstrb;
        if (owner_q) m1.req_ready = core.req_ready;
        else         m0.req_ready = core.req_ready;
        // A withdrawn request releases the port without issuing anything.
        if (!own_valid) begin
          state_d = ST_IDLE;
        end else if (core.req_ready) begin
          state_d      = ST_WAIT;
          last_owner_d = owner_q;
          if (owner_q) cnt1_d = sat_inc(cnt1_q);
          else         cnt0_d = sat_inc(cnt0_q);
        end
      end

      ST_WAIT: begin
        if (core.resp_valid) begin
          if (owner_q) m1.resp_valid = 1'b1;
          else         m0.resp_valid = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Completions with nothing outstanding are dropped and remembered.
    if (core.resp_valid && (state_q != ST_WAIT)) spur_d = 1'b1;
  end

  assign m0.resp_is_write = core.resp_is_write;
  assign m0.resp_rdata    = core.resp_rdata;
  assign m0.resp_resp     = core.resp_resp;
  assign m1.resp_is_write = core.resp_is_write;
  assign m1.resp_rdata    = core.resp_rdata;
  assign m1.resp_resp     = core.resp_resp;

  assign grant_cnt0        = cnt0_q;
  assign grant_cnt1        = cnt1_q;
  assign dbg_state         = 2'(state_q);
  assign dbg_owner         = owner_q;
  assign dbg_spurious_resp = spur_q;

endmodule

// File: tb/tb_core_port_arbiter.sv
// Directed bench for core_port_arbiter: scoreboard of expected issues and
// completions checked by a negedge monitor, plus a simple core responder.
module tb_core_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef struct {
    bit            m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  dbg_state;
  logic        dbg_owner, dbg_spur;

  core_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  core_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  core_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) core_if ();

  core_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m0                (m0_if),
    .m1                (m1_if),
    .core              (core_if),
    .grant_cnt0        (cnt0),
    .grant_cnt1        (cnt1),
    .dbg_state         (dbg_state),
    .dbg_owner         (dbg_owner),
    .dbg_spurious_resp (dbg_spur)
  );

  always #5 clk = ~clk;

  txn_t exp_issue[$];
  txn_t exp_resp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit            auto_resp;
  logic          auto_valid, auto_we, man_valid;
  logic [DW-1:0] auto_rdata, man_rdata;
  logic [1:0]    auto_code;
  logic [AW-1:0] resp_addr;
  logic          resp_we;
  txn_t          mon_e, mon_r;

  assign core_if.resp_valid    = auto_valid | man_valid;
  assign core_if.resp_is_write = man_valid ? 1'b0 : auto_we;
  assign core_if.resp_rdata    = man_valid ? man_rdata : auto_rdata;
  assign core_if.resp_resp     = man_valid ? 2'b11 : auto_code;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], 16'hC0DE} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [1:0] code_of(input logic [AW-1:0] a);
    return a[9:8];
  endfunction

  task automatic check(input string tag, input bit ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  // Core model: completes each accepted request two cycles after handshake.
  initial begin
    auto_valid = 1'b0; auto_we = 1'b0; auto_rdata = '0; auto_code = '0;
    forever begin
      @(negedge clk);
      if (rst_n && auto_resp && core_if.req_valid && core_if.req_ready) begin
        resp_addr = core_if.req_addr;
        resp_we   = core_if.req_we;
        @(posedge clk); #1;
        @(posedge clk); #1;
        auto_valid = 1'b1;
        auto_we    = resp_we;
        auto_rdata = rdata_of(resp_addr);
        auto_code  = code_of(resp_addr);
        @(posedge clk); #1;
        auto_valid = 1'b0;
      end
    end
  end

  // Scoreboard: issue order/payload and completion routing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_if.req_valid && core_if.req_ready) begin
        check("issue_expected", exp_issue.size() != 0);
        if (exp_issue.size() != 0) begin
          mon_e = exp_issue.pop_front();
          check("issue_we",    core_if.req_we    === mon_e.we);
          check("issue_addr",  core_if.req_addr  === mon_e.addr);
          check("issue_wdata", core_if.req_wdata === mon_e.wdata);
          check("issue_wstrb", core_if.req_wstrb === mon_e.wstrb);
          check("issue_ready", {m1_if.req_ready, m0_if.req_ready} === (mon_e.m ? 2'b10 : 2'b01));
          check("one_in_flight", exp_resp.size() == 0);
          exp_resp.push_back(mon_e);
        end
      end
      if (m0_if.resp_valid || m1_if.resp_valid) begin
        check("resp_expected", exp_resp.size() != 0);
        if (exp_resp.size() != 0) begin
          mon_r = exp_resp.pop_front();
          check("resp_route",   {m1_if.resp_valid, m0_if.resp_valid} === (mon_r.m ? 2'b10 : 2'b01));
          check("resp_rdata0",  m0_if.resp_rdata === rdata_of(mon_r.addr));
          check("resp_rdata1",  m1_if.resp_rdata === rdata_of(mon_r.addr));
          check("resp_iswrite", (mon_r.m ? m1_if.resp_is_write : m0_if.resp_is_write) === mon_r.we);
          check("resp_code",    (mon_r.m ? m1_if.resp_resp : m0_if.resp_resp) === code_of(mon_r.addr));
        end
      end
    end
  end

  task automatic drive_m(input bit m, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (m) begin
      m1_if.req_valid = v; m1_if.req_we = we; m1_if.req_addr = a;
      m1_if.req_wdata = d; m1_if.req_wstrb = s;
    end else begin
      m0_if.req_valid = v; m0_if.req_we = we; m0_if.req_addr = a;
      m0_if.req_wdata = d; m0_if.req_wstrb = s;
    end
  endtask

  task automatic push_exp(input bit m, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_issue.push_back('{m, we, a, d, s});
  endtask

  task automatic wait_issue_empty();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_issue.size() == 0) begin done = 1'b1; break; end
    end
    check("issue_timeout", done === 1'b1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_issue.size() == 0 && exp_resp.size() == 0 && dbg_state == 2'd0) begin
        done = 1'b1; break;
      end
    end
    check("drain_timeout", done === 1'b1);
  endtask

  task automatic run_txn(input bit m, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    push_exp(m, we, a, d, s);
    @(posedge clk); #1;
    drive_m(m, 1'b1, we, a, d, s);
    wait_issue_empty();
    @(posedge clk); #1;
    drive_m(m, 1'b0, 1'b0, '0, '0, '0);
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    auto_resp = 1'b1;
    man_valid = 1'b0;
    man_rdata = '0;
    core_if.req_ready = 1'b1;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    #3;
    check("rst_state",      dbg_state === 2'd0);
    check("rst_owner",      dbg_owner === 1'b0);
    check("rst_spur",       dbg_spur === 1'b0);
    check("rst_cnt0",       cnt0 === 16'd0);
    check("rst_cnt1",       cnt1 === 16'd0);
    check("rst_core_valid", core_if.req_valid === 1'b0);
    check("rst_core_addr",  core_if.req_addr === 32'd0);
    check("rst_ready",      {m1_if.req_ready, m0_if.req_ready} === 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single master read with one-cycle arbitration latency.
    push_exp(1'b0, 1'b0, 32'h100, '0, '0);
    @(posedge clk); #1;
    drive_m(1'b0, 1'b1, 1'b0, 32'h100, '0, '0);
    @(negedge clk);
    check("lat_idle_valid", core_if.req_valid === 1'b0);
    check("lat_idle_state", dbg_state === 2'd0);
    @(negedge clk);
    check("lat_grant_valid", core_if.req_valid === 1'b1);
    check("lat_grant_state", dbg_state === 2'd1);
    @(posedge clk); #1;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    check("single_cnt0", cnt0 === 16'd1);
    check("single_cnt1", cnt1 === 16'd0);

    // Simultaneous continuous requests after reset alternate m0, m1, m0, m1.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 32'h200, '0, '0);
      push_exp(1'b1, 1'b1, 32'h300, 32'hCAFE0001, 4'h3);
    end
    @(posedge clk); #1;
    drive_m(1'b0, 1'b1, 1'b0, 32'h200, '0, '0);
    drive_m(1'b1, 1'b1, 1'b1, 32'h300, 32'hCAFE0001, 4'h3);
    wait_issue_empty();
    @(posedge clk); #1;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    check("rr_cnt0", cnt0 === 16'd2);
    check("rr_cnt1", cnt1 === 16'd2);

    // Backpressure: m1 write held in GRANT, m0 queued behind it.
    push_exp(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    push_exp(1'b0, 1'b0, 32'h80, '0, '0);
    @(posedge clk); #1;
    core_if.req_ready = 1'b0;
    drive_m(1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    drive_m(1'b0, 1'b1, 1'b0, 32'h80, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", core_if.req_valid === 1'b1);
      check("bp_we",    core_if.req_we === 1'b1);
      check("bp_addr",  core_if.req_addr === 32'h40);
      check("bp_wdata", core_if.req_wdata === 32'h12345678);
      check("bp_wstrb", core_if.req_wstrb === 4'hF);
      check("bp_ready", {m1_if.req_ready, m0_if.req_ready} === 2'b00);
      check("bp_owner", dbg_owner === 1'b1);
    end
    @(posedge clk); #1;
    core_if.req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_issue_empty();
    @(posedge clk); #1;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    check("bp_cnt0", cnt0 === 16'd3);
    check("bp_cnt1", cnt1 === 16'd3);

    // Spurious completion in IDLE is dropped and latched.
    @(posedge clk); #1;
    man_valid = 1'b1;
    man_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("spur_resp_valid", {m1_if.resp_valid, m0_if.resp_valid} === 2'b00);
    check("spur_pre_flag", dbg_spur === 1'b0);
    @(posedge clk); #1;
    man_valid = 1'b0;
    @(negedge clk);
    check("spur_flag", dbg_spur === 1'b1);
    run_txn(1'b0, 1'b1, 32'h10C, 32'h0BADF00D, 4'h5);
    check("spur_sticky", dbg_spur === 1'b1);
    check("spur_cnt0", cnt0 === 16'd4);

    // Counter saturation: preload near the top, then keep granting.
    @(negedge clk);
    force dut.cnt0_q = 16'hFFFD;
    #1;
    release dut.cnt0_q;
    run_txn(1'b0, 1'b0, 32'h204, '0, '0);
    check("sat_cnt0_fffe", cnt0 === 16'hFFFE);
    run_txn(1'b0, 1'b0, 32'h208, '0, '0);
    check("sat_cnt0_ffff", cnt0 === 16'hFFFF);
    run_txn(1'b0, 1'b0, 32'h20C, '0, '0);
    check("sat_cnt0_hold", cnt0 === 16'hFFFF);
    push_exp(1'b1, 1'b1, 32'h600, 32'h600D0006, 4'hC);
    push_exp(1'b0, 1'b0, 32'h700, '0, '0);
    @(posedge clk); #1;
    drive_m(1'b0, 1'b1, 1'b0, 32'h700, '0, '0);
    drive_m(1'b1, 1'b1, 1'b1, 32'h600, 32'h600D0006, 4'hC);
    wait_issue_empty();
    @(posedge clk); #1;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    check("sat_cnt0_after", cnt0 === 16'hFFFF);
    check("sat_cnt1_after", cnt1 === 16'd4);

    // Reset while WAIT abandons the transaction; a late completion is spurious.
    auto_resp = 1'b0;
    push_exp(1'b1, 1'b0, 32'h500, '0, '0);
    @(posedge clk); #1;
    drive_m(1'b1, 1'b1, 1'b0, 32'h500, '0, '0);
    wait_issue_empty();
    @(posedge clk); #1;
    drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("rw_in_wait", dbg_state === 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_state", dbg_state === 2'd0);
    check("rw_owner", dbg_owner === 1'b0);
    check("rw_spur",  dbg_spur === 1'b0);
    check("rw_cnt0",  cnt0 === 16'd0);
    check("rw_cnt1",  cnt1 === 16'd0);
    check("rw_core_valid", core_if.req_valid === 1'b0);
    check("rw_core_addr",  core_if.req_addr === 32'd0);
    check("rw_resp_valid", {m1_if.resp_valid, m0_if.resp_valid} === 2'b00);
    exp_resp.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    man_valid = 1'b1;
    man_rdata = 32'h1A7E1A7E;
    @(negedge clk);
    check("late_resp_valid", {m1_if.resp_valid, m0_if.resp_valid} === 2'b00);
    @(posedge clk); #1;
    man_valid = 1'b0;
    @(negedge clk);
    check("late_spur", dbg_spur === 1'b1);
    auto_resp = 1'b1;
    run_txn(1'b1, 1'b0, 32'h304, '0, '0);
    check("post_rst_cnt1", cnt1 === 16'd1);
    check("post_rst_cnt0", cnt0 === 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
